// File: rtl/sfifo_rx_3tuner_if.sv
// sfifo_rx_3tuner_if -- FX2 slave-FIFO, buffer-write and packet-status bundle
// for sfifo_rx_3tuner. master = the receiver block, slave = its environment.
interface sfifo_rx_3tuner_if;
    // FX2 side
    logic        flaga;
    logic [7:0]  fd;
    logic [1:0]  fadd;
    logic        sloe;
    logic        slrd;
    logic        slwr;
    // double-buffer write port
    logic        wb_wen;
    logic [8:0]  wb_wadd;
    logic [7:0]  wb_wdata;
    // packet status / consumer handshake
    logic        pkt_rdy;
    logic        pkt_half;
    logic [12:0] pkt_pid;
    logic        buf_rel;
    logic        buf_rel_half;
    logic        sync_err;
    logic [15:0] pkt_cnt;

    modport master (
        input  flaga, fd, buf_rel, buf_rel_half,
        output fadd, sloe, slrd, slwr,
               wb_wen, wb_wadd, wb_wdata,
               pkt_rdy, pkt_half, pkt_pid, sync_err, pkt_cnt
    );

    modport slave (
        output flaga, fd, buf_rel, buf_rel_half,
        input  fadd, sloe, slrd, slwr,
               wb_wen, wb_wadd, wb_wdata,
               pkt_rdy, pkt_half, pkt_pid, sync_err, pkt_cnt
    );
endinterface

// File: rtl/sfifo_rx_3tuner.sv
// sfifo_rx_3tuner -- reads fixed-length TS packets from an FX2 OUT endpoint
// into a two-half ping-pong buffer and announces each completed packet.
// Optional feature: define SFIFO_RX_SYNC_CHECK_EN to drop bytes at packet
// offset 0 until the 8'h47 sync byte is seen (each drop pulses sync_err).
module sfifo_rx_3tuner #(
    parameter int unsigned PKT_LEN = 188,
    parameter logic [1:0]  FADDR   = 2'b00
) (
    input  logic               clk,
    input  logic               rst,
    sfifo_rx_3tuner_if.master  bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OE   = 2'd1,
        READ = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [7:0] LAST_IDX = 8'(PKT_LEN - 1);

    state_t      state;
    state_t      state_nx;
    logic        sloe_c;
    logic        slrd_c;

    logic [7:0]  cnt;
    logic        wr_half;
    logic [1:0]  half_full;
    logic [1:0]  half_full_nx;
    logic [12:0] pid;
    logic [15:0] pkt_cnt;
    logic        wen;
    logic [8:0]  wadd;
    logic [7:0]  wdata;
    logic        rdy;
    logic        rdy_half;

    logic        take;       // a byte is strobed out of the FX2 on this edge
    logic        hunt_drop;  // consumed byte is discarded while hunting sync
    logic        last;       // consumed byte is the final one of the packet

`ifdef SFIFO_RX_SYNC_CHECK_EN
    logic        sync_err_r;
    assign hunt_drop = (cnt == '0) && (bus.fd != 8'h47);
    assign bus.sync_err = sync_err_r;
`else
    assign hunt_drop = 1'b0;
    assign bus.sync_err = 1'b0;
`endif

    assign take = (state == READ) && bus.flaga;
    assign last = take && !hunt_drop && (cnt == LAST_IDX);

    assign bus.fadd     = FADDR;
    assign bus.slwr     = 1'b1;
    assign bus.sloe     = sloe_c;
    assign bus.slrd     = slrd_c;
    assign bus.wb_wen   = wen;
    assign bus.wb_wadd  = wadd;
    assign bus.wb_wdata = wdata;
    assign bus.pkt_rdy  = rdy;
    assign bus.pkt_half = rdy_half;
    assign bus.pkt_pid  = pid;
    assign bus.pkt_cnt  = pkt_cnt;

    // state register
    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else      state <= state_nx;
    end

    // next state and FX2 strobes; slrd follows flaga directly so a pause costs no cycles
    always_comb begin
        state_nx = state;
        sloe_c   = 1'b1;
        slrd_c   = 1'b1;
        case (state)
            IDLE: begin
                if (bus.flaga && !half_full[wr_half]) state_nx = OE;
            end
            OE: begin
                sloe_c   = 1'b0;
                state_nx = READ;
            end
            READ: begin
                sloe_c = 1'b0;
                slrd_c = ~bus.flaga;
                if (last) state_nx = DONE;
            end
            DONE: begin
                sloe_c   = 1'b0;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // buffer-half occupancy: a DONE set overrides a same-cycle release of that half
    always_comb begin
        half_full_nx = half_full;
        if (bus.buf_rel)     half_full_nx[bus.buf_rel_half] = 1'b0;
        if (state == DONE)   half_full_nx[wr_half]          = 1'b1;
    end

    // byte capture, write port, PID capture and packet completion bookkeeping
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt       <= '0;
            wr_half   <= 1'b0;
            half_full <= '0;
            pid       <= '0;
            pkt_cnt   <= '0;
            wen       <= 1'b0;
            wadd      <= '0;
            wdata     <= '0;
            rdy       <= 1'b0;
            rdy_half  <= 1'b0;
`ifdef SFIFO_RX_SYNC_CHECK_EN
            sync_err_r <= 1'b0;
`endif
        end else begin
            wen       <= 1'b0;
            rdy       <= 1'b0;
            half_full <= half_full_nx;
`ifdef SFIFO_RX_SYNC_CHECK_EN
            sync_err_r <= 1'b0;
`endif
            if (take) begin
                if (hunt_drop) begin
`ifdef SFIFO_RX_SYNC_CHECK_EN
                    sync_err_r <= 1'b1;
`endif
                end else begin
                    wen   <= 1'b1;
                    wadd  <= {wr_half, cnt};
                    wdata <= bus.fd;
                    if (cnt == 8'd1) pid[12:8] <= bus.fd[4:0];
                    if (cnt == 8'd2) pid[7:0]  <= bus.fd;
                    cnt <= last ? '0 : cnt + 8'd1;
                end
            end
            if (state == DONE) begin
                rdy      <= 1'b1;
                rdy_half <= wr_half;
                wr_half  <= ~wr_half;
                pkt_cnt  <= pkt_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_sfifo_rx_3tuner.sv
// tb_sfifo_rx_3tuner -- directed self-checking bench for sfifo_rx_3tuner.
// Models the FX2 endpoint as a byte array advanced on each slrd=0 edge and
// records every buffer write into a shadow memory.
module tb_sfifo_rx_3tuner;

    localparam int PL = 188;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    sfifo_rx_3tuner_if bus ();

    sfifo_rx_3tuner #(.PKT_LEN(PL), .FADDR(2'b00)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [7:0]  src [0:2047];
    logic [7:0]  mem [0:511];
    int          sidx;
    int          cyc;
    int          nwr, nrdy, nsync;
    int          last_wen_cyc, rdy_cyc;
    logic [8:0]  last_waddr, first_waddr;
    logic        first_pend;
    logic        rdy_half;
    logic [12:0] rdy_pid;
    logic [15:0] rdy_cnt;
    int          passes, fails, total;
    int          base_wr, base_rdy, base_sidx;

    function automatic logic [7:0] pkt_byte(input int p, input int k);
        if (k == 0) return 8'h47;
        if (k == 1) return (p == 5) ? 8'hE5 : 8'h1F;
        if (k == 2) return (p == 5) ? 8'h5A : 8'hFF;
        return 8'(k + p * 37);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // one clock: present the next FX2 byte, advance it if strobed, log outputs
    task automatic tick();
        logic strobe;
        bus.fd = src[sidx];
        #1;
        strobe = (bus.slrd === 1'b0);
        @(posedge clk);
        #1;
        cyc++;
        if (strobe) sidx++;
        if (bus.wb_wen) begin
            mem[bus.wb_wadd] = bus.wb_wdata;
            nwr++;
            last_waddr   = bus.wb_wadd;
            last_wen_cyc = cyc;
            if (first_pend) begin
                first_waddr = bus.wb_wadd;
                first_pend  = 1'b0;
            end
        end
        if (bus.pkt_rdy) begin
            nrdy++;
            rdy_half = bus.pkt_half;
            rdy_pid  = bus.pkt_pid;
            rdy_cnt  = bus.pkt_cnt;
            rdy_cyc  = cyc;
        end
        if (bus.sync_err) nsync++;
    endtask

    task automatic wait_rdy(input int target, input string tag);
        for (int n = 0; n < 600 && nrdy < target; n++) tick();
        chk(tag, nrdy, target);
    endtask

    task automatic wait_wr(input int target, input string tag);
        for (int n = 0; n < 600 && nwr < target; n++) tick();
        chk(tag, nwr, target);
    endtask

    task automatic wait_sidx(input int target, input string tag);
        for (int n = 0; n < 600 && sidx < target; n++) tick();
        chk(tag, sidx, target);
    endtask

    task automatic chk_pkt(input string tag, input int base, input int p, input int off);
        int bad = 0;
        for (int k = 0; k < PL; k++)
            if (mem[base + k] !== src[off + k]) bad++;
        chk(tag, bad, 0);
        chk({tag, "_model"}, mem[base + 3], pkt_byte(p, 3));
    endtask

    task automatic release_half(input logic h);
        bus.buf_rel      = 1'b1;
        bus.buf_rel_half = h;
        tick();
        bus.buf_rel      = 1'b0;
    endtask

    initial begin
        passes = 0; fails = 0; total = 0;
        cyc = 0; nwr = 0; nrdy = 0; nsync = 0; sidx = 0;
        first_pend = 1'b0; first_waddr = '0; last_waddr = '0;
        last_wen_cyc = 0; rdy_cyc = 0;
        rdy_half = 1'b0; rdy_pid = '0; rdy_cnt = '0;
        for (int i = 0; i < 512; i++) mem[i] = 8'h00;
        for (int i = 0; i < 2048; i++) src[i] = 8'h00;
        for (int p = 0; p < 7; p++)
            for (int k = 0; k < PL; k++) src[p * PL + k] = pkt_byte(p, k);
        src[7 * PL]     = 8'h00;
        src[7 * PL + 1] = 8'h12;
        for (int k = 0; k < PL; k++) src[7 * PL + 2 + k] = pkt_byte(7, k);

        bus.flaga = 1'b0; bus.fd = 8'h00; bus.buf_rel = 1'b0; bus.buf_rel_half = 1'b0;

        // reset state
        rst = 1'b0;
        @(posedge clk); #1;
        tick(); tick(); tick();
        chk("rst_sloe", bus.sloe, 1);
        chk("rst_slrd", bus.slrd, 1);
        chk("rst_wen", bus.wb_wen, 0);
        chk("rst_rdy", bus.pkt_rdy, 0);
        chk("rst_sync", bus.sync_err, 0);
        chk("rst_pktcnt", bus.pkt_cnt, 0);
        chk("rst_wadd", bus.wb_wadd, 0);
        chk("rst_wdata", bus.wb_wdata, 0);
        chk("rst_pid", bus.pkt_pid, 0);
        chk("fadd", bus.fadd, 2'b00);
        chk("slwr", bus.slwr, 1);

        // packet 0 -> half 0
        rst = 1'b1;
        bus.flaga = 1'b1;
        sidx = 0;
        tick();
        chk("oe_sloe", bus.sloe, 0);
        chk("oe_slrd", bus.slrd, 1);
        tick();
        chk("read_slrd", bus.slrd, 0);
        chk("read_nowr", nwr, 0);
        wait_rdy(1, "p0_rdy");
        chk("p0_nwr", nwr, 188);
        chk("p0_lastaddr", last_waddr, 9'h0BB);
        chk("p0_half", rdy_half, 0);
        chk("p0_pid", rdy_pid, 13'h1FFF);
        chk("p0_cnt", rdy_cnt, 1);
        chk("p0_latency", rdy_cyc - last_wen_cyc, 1);
        chk("p0_b0", mem[9'h000], 8'h47);
        chk("p0_b3", mem[9'h003], 8'h03);
        chk_pkt("p0_data", 0, 0, 0);

        // packet 1 -> half 1
        wait_rdy(2, "p1_rdy");
        chk("p1_nwr", nwr, 376);
        chk("p1_lastaddr", last_waddr, 9'h1BB);
        chk("p1_half", rdy_half, 1);
        chk("p1_cnt", rdy_cnt, 2);
        chk_pkt("p1_data", 9'h100, 1, PL);

        // both halves full: block must not read
        base_sidx = sidx;
        for (int n = 0; n < 20; n++) tick();
        chk("full_sloe", bus.sloe, 1);
        chk("full_slrd", bus.slrd, 1);
        chk("full_nwr", nwr, 376);
        chk("full_sidx", sidx, base_sidx);

        // release half 0 -> packet 2 into half 0
        release_half(1'b0);
        wait_rdy(3, "p2_rdy");
        chk("p2_half", rdy_half, 0);
        chk("p2_cnt", rdy_cnt, 3);
        chk("p2_b3", mem[9'h003], 8'h4D);
        chk("p2_bBB", mem[9'h0BB], 8'h05);
        chk_pkt("p2_data", 0, 2, 2 * PL);

        // packet 3 into half 1, flaga paused 3 cycles at byte 50
        base_wr = nwr;
        release_half(1'b1);
        wait_sidx(3 * PL + 50, "p3_reach50");
        bus.flaga = 1'b0;
        for (int n = 0; n < 3; n++) begin
            tick();
            chk("pause_wen", bus.wb_wen, 0);
            chk("pause_slrd", bus.slrd, 1);
        end
        chk("pause_sidx", sidx, 3 * PL + 50);
        chk("pause_nwr", nwr, base_wr + 50);
        bus.flaga = 1'b1;
        #1;
        chk("resume_slrd", bus.slrd, 0);
        wait_rdy(4, "p3_rdy");
        chk("p3_nwr", nwr, base_wr + 188);
        chk("p3_half", rdy_half, 1);
        chk("p3_b50", mem[9'h132], 8'hA1);
        chk_pkt("p3_data", 9'h100, 3, 3 * PL);

        // packet 4 aborted by reset at byte 100
        release_half(1'b0);
        wait_sidx(4 * PL + 100, "p4_reach100");
        base_rdy = nrdy;
        rst = 1'b0;
        tick(); tick();
        chk("abort_pktcnt", bus.pkt_cnt, 0);
        chk("abort_sloe", bus.sloe, 1);
        chk("abort_wadd", bus.wb_wadd, 0);
        rst = 1'b1;
        sidx = 5 * PL;
        first_pend = 1'b1;
        base_wr = nwr;

        // packet 5 -> half 0; release of not-full half 1 coincides with DONE
        wait_wr(base_wr + 188, "p5_nwr");
        bus.buf_rel      = 1'b1;
        bus.buf_rel_half = 1'b1;
        tick();
        bus.buf_rel      = 1'b0;
        chk("p5_rdy_only_one", nrdy, base_rdy + 1);
        chk("p5_first_addr", first_waddr, 9'h000);
        chk("p5_half", rdy_half, 0);
        chk("p5_pid", rdy_pid, 13'h055A);
        chk("p5_cnt", rdy_cnt, 1);
        chk_pkt("p5_data", 0, 5, 5 * PL);

        // packet 6 -> half 1; release of half 1 coincident with its DONE loses
        base_wr = nwr;
        wait_wr(base_wr + 188, "p6_nwr");
        bus.buf_rel      = 1'b1;
        bus.buf_rel_half = 1'b1;
        tick();
        bus.buf_rel      = 1'b0;
        chk("p6_rdy", nrdy, base_rdy + 2);
        chk("p6_half", rdy_half, 1);
        chk("p6_cnt", rdy_cnt, 2);
        chk_pkt("p6_data", 9'h100, 6, 6 * PL);
        base_wr = nwr;
        for (int n = 0; n < 15; n++) tick();
        chk("setwins_sloe", bus.sloe, 1);
        chk("setwins_nwr", nwr, base_wr);
        chk("setwins_sidx", sidx, 7 * PL);

        // stream 00,12 then packet 7 into half 0
        first_pend = 1'b1;
        release_half(1'b0);
        release_half(1'b1);
        wait_rdy(base_rdy + 3, "p7_rdy");
        chk("p7_first_addr", first_waddr, 9'h000);
        chk("p7_half", rdy_half, 0);
`ifdef SFIFO_RX_SYNC_CHECK_EN
        chk("sync_pulses", nsync, 2);
        chk("sync_b0", mem[9'h000], 8'h47);
        chk("sync_b1", mem[9'h001], 8'h1F);
        chk("sync_nwr", nwr, base_wr + 188);
        chk_pkt("p7_data", 0, 7, 7 * PL + 2);
`else
        chk("nosync_pulses", nsync, 0);
        chk("nosync_b0", mem[9'h000], 8'h00);
        chk("nosync_b1", mem[9'h001], 8'h12);
        chk("nosync_b2", mem[9'h002], 8'h47);
`endif

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule

// File: doc/sfifo_rx_3tuner.md
SFIFO_RX_3TUNER -- requirements
Module: sfifo_rx_3tuner

Interface
REQ-001 SHALL have parameter PKT_LEN, default 188, bytes per packet.
REQ-002 SHALL have parameter FADDR, default 2'b00, FX2 OUT endpoint address.
REQ-003 clk  in  1  clock, all logic on rising edge.
REQ-004 rst  in  1  reset, synchronous, active-low.
REQ-005 flaga  in  1  FX2 OUT-endpoint empty flag, low = empty.
REQ-006 fd  in  8  FX2 FIFO data bus.
REQ-007 fadd  out  2  FIFO address, constant FADDR.
REQ-008 sloe  out  1  FX2 output enable, active-low.
REQ-009 slrd  out  1  FX2 read strobe, active-low.
REQ-010 slwr  out  1  FX2 write strobe, constant 1.
REQ-011 wb_wen  out  1  buffer write enable, active-high.
REQ-012 wb_wadd  out  9  buffer address {half, byte index}.
REQ-013 wb_wdata  out  8  buffer write data.
REQ-014 pkt_rdy  out  1  one-cycle pulse, packet complete.
REQ-015 pkt_half  out  1  half holding the completed packet, valid with pkt_rdy.
REQ-016 pkt_pid  out  13  PID {byte1[4:0], byte2}, valid with pkt_rdy.
REQ-017 buf_rel  in  1  consumer release pulse.
REQ-018 buf_rel_half  in  1  half released by buf_rel.
REQ-019 sync_err  out  1  one-cycle pulse, byte dropped while hunting sync.
REQ-020 pkt_cnt  out  16  count of completed packets.

Function
REQ-021 SHALL run FSM IDLE, OE, READ, DONE.
REQ-022 IDLE->OE when flaga=1 and half_full[wr_half]=0; otherwise stay in IDLE.
REQ-023 OE: sloe=0, slrd=1 for exactly one cycle (bus turnaround), then ->READ.
REQ-024 READ: sloe=0; slrd = ~flaga (combinational). A byte is consumed on each edge with slrd=0.
REQ-025 flaga=0 in READ SHALL pause reading without leaving READ; reading resumes when flaga=1.
REQ-026 Each consumed byte SHALL be written with 1-cycle latency: wb_wen=1, wb_wadd={wr_half, cnt}, wb_wdata=fd registered.
REQ-027 cnt SHALL be 8 bits, increment per written byte, and range 0..PKT_LEN-1.
REQ-028 Bytes at cnt=1 and cnt=2 SHALL be captured into pkt_pid.
REQ-029 When the byte at cnt=PKT_LEN-1 is consumed, the FSM SHALL go ->DONE, slrd=1, and cnt=0.
REQ-030 DONE SHALL last one cycle and perform all of the following, then go ->IDLE with sloe=1:
- set half_full[wr_half];
- pulse pkt_rdy with pkt_half = old wr_half;
- toggle wr_half;
- increment pkt_cnt, wrapping 0xFFFF->0.
REQ-031 pkt_rdy SHALL be asserted one cycle after the last wb_wen of the packet.
REQ-032 buf_rel SHALL clear half_full[buf_rel_half]; a release of a half that is not full SHALL be ignored.
REQ-033 If buf_rel and the DONE set target the same half in the same cycle, the set SHALL win.
REQ-034 With both halves full, the block SHALL stay in IDLE with sloe=slrd=1; no FX2 byte is consumed.

Reset
REQ-035 rst=0 SHALL force all of the following:
- FSM to IDLE;
- sloe=1, slrd=1, wb_wen=0, pkt_rdy=0, sync_err=0;
- cnt=0, wr_half=0, half_full=2'b00, pkt_pid=0, pkt_cnt=0;
- wb_wadd=0, wb_wdata=0.
REQ-036 Reset mid-packet SHALL abort the packet: no pkt_rdy is generated and partial data is discarded.
REQ-037 fadd and slwr SHALL hold their constant values regardless of reset.

Configuration
REQ-038 Macro SFIFO_RX_SYNC_CHECK_EN defined:
- in READ at cnt=0, a consumed byte with fd!=8'h47 SHALL NOT be written;
- sync_err SHALL pulse one cycle later;
- cnt SHALL stay 0 (hunt) until 8'h47 is consumed.
REQ-039 Macro SFIFO_RX_SYNC_CHECK_EN undefined: the byte at cnt=0 SHALL be accepted unconditionally, and sync_err SHALL be tied 0.

Verification
REQ-040 flaga=1 steady, 188 bytes 47,1F,FF,03.. -> OE one cycle; 188 wb_wen at addr 0x000..0x0BB; pkt_rdy with pkt_half=0, pkt_pid=0x1FFF, pkt_cnt=1.
REQ-041 Two packets with no buf_rel, third available -> halves 0 and 1 filled (addr 0x100..0x1BB); block then idles with sloe=1; buf_rel with half 0 -> third packet written to half 0.
REQ-042 flaga dropped for 3 cycles at byte 50 -> slrd=1 for those cycles; no wb_wen; bytes 50..187 written contiguously afterward.
REQ-043 rst=0 pulsed at byte 100 -> no pkt_rdy; next packet starts at addr 0x000 with pkt_cnt=0.
REQ-044 SFIFO_RX_SYNC_CHECK_EN defined, stream 00,12,47,... -> two sync_err pulses; 8'h47 written at addr 0x000.
REQ-045 buf_rel for a half not full, issued coincident with DONE on the other half -> half_full reflects only the set.
